timer_device: RTL

- Memory-mapped countdown timer on the processor bridge.
- Sits directly downstream of the data-memory stage and consumes its bridge outputs (address, byte enables, shifted write data, write enable); returns read data and an interrupt request.
- Each instance occupies 16 bytes at BASE_ADDR: CTRL at +0x0, PRESET at +0x4, COUNT at +0x8 (read-only).
- Two instances are planned, at 0x7f00 and 0x7f10.

---
 rtl/timer_pkg.sv | 30 +++
 rtl/timer_device_be_merge.sv | 17 +
 rtl/timer_device.sv | 123 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode encodings.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] CTRL_OFS   = 2'd0;
   localparam logic [1:0] PRESET_OFS = 2'd1;
   localparam logic [1:0] COUNT_OFS  = 2'd2;

   localparam int EN_BIT   = 0;
   localparam int MODE_LSB = 1;
   localparam int MODE_MSB = 2;
   localparam int IM_BIT   = 3;
   localparam int IRQS_BIT = 4;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Modes 1x are reserved and fall back to one-shot behaviour.
   function automatic logic is_reload(input logic [3:0] ctrl);
      return ctrl[MODE_MSB:MODE_LSB] == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/timer_device_be_merge.sv
// Byte-enable merge: each output byte comes from new_word where its enable
// is set, otherwise from old_word.
module be_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  be,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/timer_device.sv
// Countdown timer on the processor bridge: CTRL/PRESET/COUNT registers and
// an interrupt request. Define TIMER_IRQ_STATUS_EN to expose irq_flag as CTRL bit4.
module timer_device
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pr_addr,
   input  logic        pr_we,
   input  logic [3:0]  pr_be,
   input  logic [31:0] pr_wdata,
   output logic [31:0] pr_rdata,
   output logic        irq
);

   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic        hit;
   logic [1:0]  sel;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        ctrl_wr_en;
   logic [31:0] preset_merged;
   logic        irq_set;
   logic        irqs_clr;
   logic        unused_bits;

   assign hit        = pr_addr[31:4] == BASE_ADDR[31:4];
   assign sel        = pr_addr[3:2];
   assign wr_ctrl    = hit && pr_we && (sel == CTRL_OFS);
   assign wr_preset  = hit && pr_we && (sel == PRESET_OFS);
   assign ctrl_wr_en = wr_ctrl && pr_be[0];
   assign irq_set    = (state == CNT) && ctrl[EN_BIT] && (count <= 32'd1);
   assign unused_bits = ^{pr_addr[1:0], BASE_ADDR[3:0]};

`ifdef TIMER_IRQ_STATUS_EN
   assign irqs_clr = ctrl_wr_en && pr_wdata[IRQS_BIT];
`else
   assign irqs_clr = 1'b0;
`endif

   be_merge u_preset_merge (
      .old_word (preset),
      .new_word (pr_wdata),
      .be       (pr_be),
      .merged   (preset_merged)
   );

   // NOTE: sequential state uses non-blocking assignments only; when two
   // assignments to the same register land on one edge, the later one wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         if (wr_preset) preset <= preset_merged;

         unique case (state)
            IDLE: if (ctrl[EN_BIT]) state <= LOAD;
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!ctrl[EN_BIT]) begin
                  state <= IDLE;
               end else if (count <= 32'd1) begin
                  count <= '0;
                  state <= INT;
               end else begin
                  count <= count - 32'd1;
               end
            end
            INT: begin
               if (!is_reload(ctrl)) ctrl[EN_BIT] <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Placed after the FSM so a software CTRL write beats the INT clear.
         if (ctrl_wr_en) ctrl <= pr_wdata[3:0];

         if (irqs_clr)
            irq_flag <= 1'b0;
         else if (irq_set)
            irq_flag <= 1'b1;
         else if ((state == INT) && is_reload(ctrl))
            irq_flag <= 1'b0;
         else if (wr_ctrl || wr_preset)
            irq_flag <= 1'b0;
      end
   end

   assign irq = irq_flag && ctrl[IM_BIT];

   always_comb begin
      pr_rdata = '0;
      if (hit) begin
         unique case (sel)
            CTRL_OFS: begin
               pr_rdata[3:0] = ctrl;
`ifdef TIMER_IRQ_STATUS_EN
               pr_rdata[IRQS_BIT] = irq_flag;
`endif
            end
            PRESET_OFS: pr_rdata = preset;
            COUNT_OFS:  pr_rdata = count;
            default:    pr_rdata = '0;
         endcase
      end
   end

endmodule
